int8_dot_acc: RTL
=================

// Module: int8_dot_acc
// PURPOSE
//  Downstream stage of the vector ALU int8 multiplier. Consumes its registered 16-bit unsigned
//  products over a valid/ready stream and accumulates them into a dot-product sum.
//  Emits one result per vector, delimited by in_last or by the length limit, then waits for a result handshake.
// PARAMETERS
//  ACC_W  32  accumulator/result width; legal range 17..48
//  LEN_W  8   beat-counter width; maximum vector length MAX_LEN = 2**LEN_W-1 beats
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      in_prod/in_last valid
//  in_ready   out  1      stage can accept a beat
//  in_prod    in   16     unsigned product (multiplier output)
//  in_last    in   1      final beat of current vector
//  out_valid  out  1      result held on out_sum/out_cnt/out_ovf/out_trunc
//  out_ready  in   1      result consumer ready
//  out_sum    out  ACC_W  accumulated sum
//  out_cnt    out  LEN_W  number of beats accumulated (1..MAX_LEN)
//  out_ovf    out  1      sum exceeded 2**ACC_W-1 at some beat of this vector (sticky per vector)
//  out_trunc  out  1      vector closed by length limit, not by in_last
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=ACC, acc=0, cnt=0, ovf=0.
//    Outputs after reset: out_valid=0, out_sum=0, out_cnt=0, out_ovf=0, out_trunc=0, in_ready=1.
//  - Reset mid-vector or mid-DONE: partial sum and pending result are discarded; no result is emitted.
//  - FSM, 2 states:
//    ACC : in_ready=1, out_valid=0. Beat accepted when in_valid&in_ready.
//          Each accepted beat: acc<=acc+zext(in_prod), cnt<=cnt+1.
//          If in_last=1 or cnt+1==MAX_LEN, that beat closes the vector:
//            - out_sum <= acc+in_prod; out_cnt <= cnt+1;
//            - out_trunc <= ~in_last; go to DONE.
//            - acc/cnt/ovf cleared in the same edge.
//    DONE: in_ready=0, out_valid=1, all outputs stable. out_valid&out_ready -> ACC.
//          Without out_ready, hold indefinitely.
//  - Latency: result is valid the cycle after the closing beat is accepted.
//  - Throughput: one beat/cycle within a vector; one bubble cycle per vector (DONE blocks input).
//  - in_valid while in_ready=0: ignored; the upstream stage holds its data.
//  - Vector of length 1 with in_last: out_cnt=1, out_sum=in_prod.
//  - Overflow: carry out of the ACC_W-bit add sets ovf; ovf is sticky until the vector closes.
//  - in_prod is always treated as unsigned; no sign extension.
// CONFIGURATION
//  - SATURATE_EN defined: on overflow, acc clamps to 2**ACC_W-1 and stays clamped for the rest of
//    the vector; out_ovf is still reported.
//  - SATURATE_EN undefined: acc wraps modulo 2**ACC_W; out_ovf is reported.
//  - No other difference between the two builds.
// STRUCTURE
//  - Package int_vec_pkg: state typedef {ACC,DONE}; PROD_W=16 constant; MAX_LEN function of LEN_W.
//  - Sub-module dot_acc_add: combinational ACC_W adder (acc, zext prod) -> (sum, carry).
//    Wrap/saturate selection lives in this sub-module under SATURATE_EN.
//  - The top level holds the FSM, counters, and output registers.
// TESTING
//  1. Reset: assert rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, out_sum=0 on the next cycle.
//  2. Basic vector: products 100,200,300(last), out_ready=1 -> out_sum=600, out_cnt=3,
//     out_ovf=0, out_trunc=0; out_valid for exactly 1 cycle.
//  3. Backpressure: close the vector with out_ready=0 for 5 cycles -> out_valid held, in_ready=0,
//     held in_valid beat not consumed. Release -> next vector starts from acc=0.
//  4. Length limit (LEN_W=8): stream 255 beats of 65025 with no last -> out_cnt=255,
//     out_sum=16581375, out_trunc=1.
//  5. Overflow (ACC_W=17): beats 65535,65535 (last).
//     - Without SATURATE_EN: out_sum=131070-131072 mod -> 131070, out_ovf=0.
//     - Beats 65535,65535,65535: out_sum=65533, out_ovf=1.
//     - With SATURATE_EN: out_sum=131071, out_ovf=1.
//  6. Reset mid-vector: 2 beats accepted, then rst_n=0 -> no out_valid.
//     Next vector 7(last) -> out_sum=7, out_cnt=1.

Source files
------------

// File: rtl/int_vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_vec_pkg
//  Brief    : Shared types and constants for the int8 vector ALU dot-product
//             accumulator stage.
//  Revision : 1.0  initial release
// ============================================================================
package int_vec_pkg;

    // Width of an unsigned int8 x int8 product delivered by the multiplier.
    localparam int PROD_W = 16;

    // Two-state accumulator FSM, explicitly one bit wide.
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Longest vector a LEN_W-bit beat counter can describe.
    function automatic int max_len(input int len_w);
        return (1 << len_w) - 1;
    endfunction

endpackage : int_vec_pkg
`default_nettype wire

// File: rtl/dot_acc_add.sv
`default_nettype none
// ============================================================================
//  Module   : dot_acc_add
//  Brief    : Combinational accumulator adder: acc + zero-extended product,
//             with carry-out. Build option SATURATE_EN clamps the sum to
//             all-ones on carry; otherwise the sum wraps.
//  Revision : 1.0  initial release
// ============================================================================
module dot_acc_add
    import int_vec_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W:0] w_full;

    // One extra bit captures the carry; the product is always unsigned.
    assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    assign o_carry = w_full[ACC_W];

`ifdef SATURATE_EN
    // Once clamped, any further non-zero product carries again, so the
    // accumulator stays pinned at the maximum for the rest of the vector.
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule : dot_acc_add
`default_nettype wire

// File: rtl/int8_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : int8_dot_acc
//  Brief    : Accumulates a valid/ready stream of 16-bit unsigned products into
//             one dot-product result per vector (closed by in_last or by the
//             beat-count limit) and holds it until handshaked.
//             Optional macro: SATURATE_EN (clamp instead of wrap on overflow).
//  Revision : 1.0  initial release
// ============================================================================
module int8_dot_acc
    import int_vec_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [LEN_W-1:0]  out_cnt,
    output logic              out_ovf,
    output logic              out_trunc
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(max_len(LEN_W));

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_sum;
    logic [LEN_W-1:0]   r_out_cnt;
    logic               r_out_ovf;
    logic               r_out_trunc;

    logic               w_accept;
    logic               w_close;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    dot_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_prod  (in_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Handshake flags come straight from the state register.
    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == DONE);

    assign w_accept  = in_valid & in_ready;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_close   = w_accept & (in_last | (w_cnt_nxt == C_MAX_LEN));

    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;
    assign out_trunc = r_out_trunc;

    // FSM, running accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_trunc <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_close) begin
                        // Closing beat: publish result, restart the vector.
                        r_out_sum   <= w_sum;
                        r_out_cnt   <= w_cnt_nxt;
                        r_out_ovf   <= r_ovf | w_carry;
                        r_out_trunc <= ~in_last;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= DONE;
                    end else if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= r_ovf | w_carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

endmodule : int8_dot_acc
`default_nettype wire
